snow_wt_cache: RTL and testbench

SNOW_WT_CACHE -- requirements
Module: snow_wt_cache

---
 rtl/snow_wt_cache.sv | 211 +++++++++++++++++++++
 tb/tb_snow_wt_cache.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snow_wt_cache.sv
// snow_wt_cache: direct-mapped, write-through, no-write-allocate cache with a
// FIFO write buffer, line-fill bursts, uncached reads and a valid-bit sweep.
module snow_wt_cache #(
   parameter int IDX_W      = 8,
   parameter int LINE_W     = 1,
   parameter int WBUF_DEPTH = 4
) (
   input  logic        CPU_CLK,
   input  logic        RST,
   input  logic        cpu_en,
   input  logic        cpu_we,
   input  logic        cpu_inhibit,
   input  logic        cpu_inv,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_datao,
   output logic [31:0] cpu_datai,
   output logic        cpu_busy,
   output logic        mem_act,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_dataintomem,
   input  logic        mem_ack,
   input  logic [31:0] mem_datafrommem
);

   localparam int TAG_W = 30 - IDX_W - LINE_W;
   localparam int LINES = 1 << IDX_W;
   localparam int WORDS = 1 << (IDX_W + LINE_W);
   localparam int WB_AW = $clog2(WBUF_DEPTH);
   localparam logic [WB_AW:0] WB_FULL = (WB_AW + 1)'(WBUF_DEPTH);

   typedef enum logic [2:0] {IDLE, DRAIN_WAIT, FILL, UNC_READ, INVAL} state_t;
   state_t r_state, w_next;

   logic [31:0]       r_data [WORDS];
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [LINES-1:0]  r_valid;

   logic              r_pend, r_pwe, r_pinh, r_inv_lat;
   logic [31:0]       r_paddr, r_pdata, r_unc_data;
   logic [LINE_W-1:0] r_fill_off;
   logic [IDX_W-1:0]  r_sweep;

   logic [31:0]       r_wb_addr [WBUF_DEPTH];
   logic [31:0]       r_wb_data [WBUF_DEPTH];
   logic [WB_AW-1:0]  r_wb_wr, r_wb_rd;
   logic [WB_AW:0]    r_wb_cnt;

   logic [IDX_W-1:0]        w_idx;
   logic [LINE_W-1:0]       w_off;
   logic [TAG_W-1:0]        w_tag;
   logic [IDX_W+LINE_W-1:0] w_word;
   logic w_hit, w_wb_empty, w_wb_full, w_drain, w_pop, w_push;
   logic w_fill_ack, w_fill_last, w_unc_done, w_rd_mem, w_wr_stall, w_inv;
   logic w_busy, w_accept, w_consume, w_inv_take;
   logic w_act, w_we;
   logic [31:0] w_maddr, w_mdata;
   logic w_unused_lsb;

   assign w_idx  = r_paddr[IDX_W+LINE_W+1:LINE_W+2];
   assign w_off  = r_paddr[LINE_W+1:2];
   assign w_tag  = r_paddr[31:IDX_W+LINE_W+2];
   assign w_word = {w_idx, w_off};
   assign w_unused_lsb = ^r_paddr[1:0];

   assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_wb_empty = (r_wb_cnt == '0);
   assign w_wb_full  = (r_wb_cnt == WB_FULL);
   // Buffer drains whenever the memory port is not owned by a read.
   assign w_drain    = (r_state != FILL) && (r_state != UNC_READ) && !w_wb_empty;
   assign w_pop      = w_drain && mem_ack;
   assign w_fill_ack  = (r_state == FILL) && mem_ack;
   assign w_fill_last = w_fill_ack && (r_fill_off == '1);
   assign w_unc_done  = (r_state == UNC_READ) && mem_ack;
   assign w_rd_mem   = r_pend && !r_pwe && (r_pinh || !w_hit);
   assign w_wr_stall = r_pend && r_pwe && w_wb_full && !w_pop;
   assign w_inv      = cpu_inv || r_inv_lat;

   // Next state, busy and request acceptance; pending work beats invalidate.
   always_comb begin
      w_next     = r_state;
      w_busy     = 1'b1;
      w_accept   = 1'b0;
      w_push     = 1'b0;
      w_consume  = 1'b0;
      w_inv_take = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (r_state == IDLE && w_rd_mem) begin
               w_busy = 1'b1;
               if (!w_wb_empty)  w_next = DRAIN_WAIT;
               else if (r_pinh)  w_next = UNC_READ;
               else              w_next = FILL;
            end else if (w_wr_stall) begin
               w_busy = 1'b1;
            end else begin
               w_push    = r_pend && r_pwe;
               w_consume = r_pend;
               if (w_inv) begin
                  w_busy     = 1'b1;
                  w_inv_take = 1'b1;
                  w_next     = INVAL;
               end else begin
                  w_accept = cpu_en;
               end
            end
         end
         DRAIN_WAIT: if (w_wb_empty) w_next = r_pinh ? UNC_READ : FILL;
         FILL:       if (w_fill_last) w_next = IDLE;
         UNC_READ:   if (mem_ack) w_next = IDLE;
         INVAL:      if (r_sweep == '1) w_next = IDLE;
         default:    w_next = IDLE;
      endcase
   end

   // Memory port: reads own it exclusively, otherwise present the buffer head.
   always_comb begin
      w_act   = 1'b0;
      w_we    = 1'b0;
      w_maddr = '0;
      w_mdata = '0;
      if (r_state == FILL) begin
         w_act   = 1'b1;
         w_maddr = {r_paddr[31:LINE_W+2], r_fill_off, 2'b00};
      end else if (r_state == UNC_READ) begin
         w_act   = 1'b1;
         w_maddr = {r_paddr[31:2], 2'b00};
      end else if (w_drain) begin
         w_act   = 1'b1;
         w_we    = 1'b1;
         w_maddr = r_wb_addr[r_wb_rd];
         w_mdata = r_wb_data[r_wb_rd];
      end
   end

   assign cpu_busy        = RST & w_busy;
   assign cpu_datai       = !RST ? '0 : (r_pinh ? r_unc_data : r_data[w_word]);
   assign mem_act         = RST & w_act;
   assign mem_we          = RST & w_we;
   assign mem_addr        = RST ? w_maddr : '0;
   assign mem_dataintomem = RST ? w_mdata : '0;

   // State register.
   always_ff @(posedge CPU_CLK) begin
      if (!RST) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // Control: pending request, valid bits, sweep/fill counters, buffer pointers.
   always_ff @(posedge CPU_CLK) begin
      if (!RST) begin
         r_pend     <= 1'b0;
         r_pwe      <= 1'b0;
         r_pinh     <= 1'b0;
         r_paddr    <= '0;
         r_pdata    <= '0;
         r_unc_data <= '0;
         r_inv_lat  <= 1'b0;
         r_valid    <= '0;
         r_sweep    <= '0;
         r_fill_off <= '0;
         r_wb_wr    <= '0;
         r_wb_rd    <= '0;
         r_wb_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_pend  <= 1'b1;
            r_pwe   <= cpu_we;
            r_pinh  <= cpu_inhibit;
            r_paddr <= cpu_addr;
            r_pdata <= cpu_datao;
         end else if (w_consume || w_fill_last || w_unc_done) begin
            r_pend <= 1'b0;
         end
         if (w_inv_take)
            r_inv_lat <= 1'b0;
         else
            r_inv_lat <= r_inv_lat | cpu_inv;
         if (w_unc_done) r_unc_data <= mem_datafrommem;
         if (r_state == INVAL) begin
            r_valid[r_sweep] <= 1'b0;
            r_sweep          <= r_sweep + 1'b1;
         end else begin
            r_sweep <= '0;
         end
         if (w_fill_last) r_valid[w_idx] <= 1'b1;
         if (w_fill_ack)            r_fill_off <= r_fill_off + 1'b1;
         else if (r_state != FILL)  r_fill_off <= '0;
         if (w_push) r_wb_wr <= r_wb_wr + 1'b1;
         if (w_pop)  r_wb_rd <= r_wb_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_wb_cnt <= r_wb_cnt + 1'b1;
            2'b01:   r_wb_cnt <= r_wb_cnt - 1'b1;
            default: r_wb_cnt <= r_wb_cnt;
         endcase
      end
   end

   // Storage arrays: fill words, tag on last beat, write-hit merge, buffer slots.
   always_ff @(posedge CPU_CLK) begin
      if (w_fill_ack) r_data[{w_idx, r_fill_off}] <= mem_datafrommem;
      if (w_fill_last) r_tag[w_idx] <= w_tag;
      if (w_push && !r_pinh && w_hit) r_data[w_word] <= r_pdata;
      if (w_push) begin
         r_wb_addr[r_wb_wr] <= {r_paddr[31:2], 2'b00};
         r_wb_data[r_wb_wr] <= r_pdata;
      end
   end

endmodule

// File: tb/tb_snow_wt_cache.sv
// tb_snow_wt_cache: directed checks of hit/miss, write buffer, uncached
// reads, invalidate sweep and reset abandonment against a simple memory model.
module tb_snow_wt_cache;

   localparam int BUDGET = 2000;

   logic        CPU_CLK = 1'b0;
   logic        RST = 1'b0;
   logic        cpu_en = 1'b0, cpu_we = 1'b0, cpu_inhibit = 1'b0, cpu_inv = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_datao = '0;
   logic [31:0] cpu_datai;
   logic        cpu_busy, mem_act, mem_we;
   logic [31:0] mem_addr, mem_dataintomem;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_datafrommem = '0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mm [logic [31:0]];
   logic [31:0] tlog [$];
   logic [31:0] dlog [$];
   logic        ack_en = 1'b1;
   int          ack_lat = 2;
   int          lat_cnt = 0;
   int          n_act = 0;
   logic        p_act = 1'b0, p_ack = 1'b0, p_we = 1'b0;
   logic [31:0] p_addr = '0, p_data = '0;

   snow_wt_cache #(.IDX_W(8), .LINE_W(1), .WBUF_DEPTH(4)) dut (
      .CPU_CLK(CPU_CLK), .RST(RST),
      .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_inhibit(cpu_inhibit), .cpu_inv(cpu_inv),
      .cpu_addr(cpu_addr), .cpu_datao(cpu_datao), .cpu_datai(cpu_datai), .cpu_busy(cpu_busy),
      .mem_act(mem_act), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_dataintomem(mem_dataintomem), .mem_ack(mem_ack), .mem_datafrommem(mem_datafrommem)
   );

   always #5 CPU_CLK = ~CPU_CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mrd(input logic [31:0] a);
      if (mm.exists(a)) return mm[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   // Memory responder: acks after ack_lat idle cycles, logs every transfer,
   // and checks that an unacknowledged request is held steady.
   always @(negedge CPU_CLK) begin
      if (RST && p_act && !p_ack) begin
         chk("mem_act_held", {31'b0, mem_act}, 32'd1);
         if (mem_act) begin
            chk("mem_we_stable", {31'b0, mem_we}, {31'b0, p_we});
            chk("mem_addr_stable", mem_addr, p_addr);
            chk("mem_data_stable", mem_dataintomem, p_data);
         end
      end
      p_act  = RST && mem_act;
      p_we   = mem_we;
      p_addr = mem_addr;
      p_data = mem_dataintomem;
      mem_ack = 1'b0;
      if (RST && mem_act && ack_en) begin
         if (lat_cnt >= ack_lat) begin
            mem_ack = 1'b1;
            lat_cnt = 0;
            tlog.push_back({mem_we, mem_addr[30:0]});
            if (mem_we) begin
               dlog.push_back(mem_dataintomem);
               mm[mem_addr] = mem_dataintomem;
            end else begin
               mem_datafrommem = mrd(mem_addr);
            end
         end else begin
            lat_cnt++;
         end
      end else begin
         lat_cnt = 0;
      end
      p_ack = mem_ack;
      if (RST && mem_act) n_act++;
   end

   task automatic cpu_rd(input logic [31:0] a, input logic inh,
                         output logic [31:0] d, output int pre, output int post);
      cpu_en = 1'b1; cpu_we = 1'b0; cpu_inhibit = inh; cpu_addr = a;
      #1;
      pre = 0;
      while (cpu_busy && pre < BUDGET) begin @(negedge CPU_CLK); #1; pre++; end
      @(negedge CPU_CLK);
      cpu_en = 1'b0;
      #1;
      post = 0;
      while (cpu_busy && post < BUDGET) begin @(negedge CPU_CLK); #1; post++; end
      d = cpu_datai;
      chk("rd_timeout", 32'((pre >= BUDGET) || (post >= BUDGET)), 32'd0);
   endtask

   task automatic cpu_wr(input logic [31:0] a, input logic [31:0] dat, input logic inh);
      int k;
      cpu_en = 1'b1; cpu_we = 1'b1; cpu_inhibit = inh; cpu_addr = a; cpu_datao = dat;
      #1;
      k = 0;
      while (cpu_busy && k < BUDGET) begin @(negedge CPU_CLK); #1; k++; end
      chk("wr_timeout", 32'(k >= BUDGET), 32'd0);
      @(negedge CPU_CLK);
      cpu_en = 1'b0; cpu_we = 1'b0;
   endtask

   task automatic wait_log(input int n);
      int k;
      k = 0;
      while (tlog.size() < n && k < BUDGET) begin @(negedge CPU_CLK); k++; end
      chk("log_timeout", 32'(k >= BUDGET), 32'd0);
      repeat (4) @(negedge CPU_CLK);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      int pre, post, base, dbase, acts, k;

      // reset values
      repeat (3) @(negedge CPU_CLK);
      #1;
      chk("rst_busy", {31'b0, cpu_busy}, 32'd0);
      chk("rst_datai", cpu_datai, 32'd0);
      chk("rst_mem_act", {31'b0, mem_act}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_dataintomem, 32'd0);
      @(negedge CPU_CLK);
      RST = 1'b1;
      #1;
      chk("idle_busy", {31'b0, cpu_busy}, 32'd0);
      chk("idle_mem_act", {31'b0, mem_act}, 32'd0);

      // cold read fills the line, neighbour word then hits
      @(negedge CPU_CLK);
      base = tlog.size();
      cpu_rd(32'h100, 1'b0, d, pre, post);
      chk("cold_data", d, 32'hA5A5_0100);
      chk("cold_is_miss", 32'(post > 0), 32'd1);
      chk("fill_len", 32'(tlog.size() - base), 32'd2);
      chk("fill_beat0", tlog[base], 32'h0000_0100);
      chk("fill_beat1", tlog[base+1], 32'h0000_0104);
      acts = n_act;
      cpu_rd(32'h104, 1'b0, d, pre, post);
      chk("hit_latency", 32'(post), 32'd0);
      chk("hit_data", d, 32'hA5A5_0104);
      chk("hit_no_mem", 32'(n_act - acts), 32'd0);

      // write hit: write through and merge into the line
      base = tlog.size(); dbase = dlog.size();
      cpu_wr(32'h100, 32'hDEAD_BEEF, 1'b0);
      wait_log(base + 1);
      chk("wt_count", 32'(tlog.size() - base), 32'd1);
      chk("wt_addr", tlog[base], 32'h8000_0100);
      chk("wt_data", dlog[dbase], 32'hDEAD_BEEF);
      cpu_rd(32'h100, 1'b0, d, pre, post);
      chk("wt_hit_latency", 32'(post), 32'd0);
      chk("wt_hit_data", d, 32'hDEAD_BEEF);

      // write miss does not allocate
      @(negedge CPU_CLK);
      base = tlog.size();
      cpu_wr(32'h300, 32'h1111_2222, 1'b0);
      cpu_rd(32'h300, 1'b0, d, pre, post);
      chk("wmiss_rd_miss", 32'(post > 0), 32'd1);
      chk("wmiss_rd_data", d, 32'h1111_2222);
      chk("wmiss_order0", tlog[base], 32'h8000_0300);
      chk("wmiss_order1", tlog[base+1], 32'h0000_0300);

      // buffered writes complete before the miss fill
      @(negedge CPU_CLK);
      base = tlog.size();
      cpu_wr(32'h400, 32'hAAAA_0001, 1'b0);
      cpu_wr(32'h404, 32'hAAAA_0002, 1'b0);
      cpu_rd(32'h500, 1'b0, d, pre, post);
      chk("drain_first0", tlog[base],   32'h8000_0400);
      chk("drain_first1", tlog[base+1], 32'h8000_0404);
      chk("drain_fill0",  tlog[base+2], 32'h0000_0500);
      chk("drain_fill1",  tlog[base+3], 32'h0000_0504);
      chk("drain_rd_data", d, 32'hA5A5_0500);

      // full buffer stalls the fifth write, FIFO order preserved
      @(negedge CPU_CLK);
      ack_en = 1'b0;
      base = tlog.size(); dbase = dlog.size();
      for (int i = 0; i < 5; i++) cpu_wr(32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
      #1;
      chk("wbuf_full_busy", {31'b0, cpu_busy}, 32'd1);
      ack_en = 1'b1;
      wait_log(base + 5);
      chk("wbuf_busy_clear", {31'b0, cpu_busy}, 32'd0);
      chk("wbuf_count", 32'(tlog.size() - base), 32'd5);
      for (int i = 0; i < 5; i++) begin
         chk("wbuf_addr", tlog[base+i], 32'h8000_0200 + 32'(4 * i));
         chk("wbuf_data", dlog[dbase+i], 32'hA000_0000 + 32'(i));
      end

      // uncached read: single word, no allocation
      base = tlog.size();
      cpu_wr(32'h600, 32'h600D_F00D, 1'b0);
      cpu_rd(32'h600, 1'b1, d, pre, post);
      chk("unc_data", d, 32'h600D_F00D);
      chk("unc_count", 32'(tlog.size() - base), 32'd2);
      chk("unc_addr", tlog[base+1], 32'h0000_0600);
      cpu_rd(32'h600, 1'b0, d, pre, post);
      chk("unc_no_alloc", 32'(post > 0), 32'd1);
      chk("unc_cached_data", d, 32'h600D_F00D);

      // invalidate beats a same-cycle request, sweeps 256 lines
      @(negedge CPU_CLK);
      cpu_inv = 1'b1; cpu_en = 1'b1; cpu_we = 1'b0; cpu_inhibit = 1'b0; cpu_addr = 32'h100;
      #1;
      chk("inv_prio_busy", {31'b0, cpu_busy}, 32'd1);
      @(negedge CPU_CLK);
      cpu_inv = 1'b0;
      base = tlog.size();
      cpu_rd(32'h100, 1'b0, d, pre, post);
      chk("inv_sweep_cycles", 32'(pre), 32'd256);
      chk("inv_then_miss", 32'(post > 0), 32'd1);
      chk("inv_refill0", tlog[base], 32'h0000_0100);
      chk("inv_refill1", tlog[base+1], 32'h0000_0104);
      chk("inv_data", d, 32'hDEAD_BEEF);

      // reset mid-fill abandons the burst and leaves nothing valid
      @(negedge CPU_CLK);
      base = tlog.size();
      cpu_en = 1'b1; cpu_we = 1'b0; cpu_inhibit = 1'b0; cpu_addr = 32'h800;
      #1;
      @(negedge CPU_CLK);
      cpu_en = 1'b0;
      #1;
      k = 0;
      while (!mem_ack && k < BUDGET) begin @(negedge CPU_CLK); #1; k++; end
      chk("rstfill_timeout", 32'(k >= BUDGET), 32'd0);
      chk("rstfill_beat0", tlog[base], 32'h0000_0800);
      @(negedge CPU_CLK);
      RST = 1'b0;
      #1;
      chk("rstfill_act_in_rst", {31'b0, mem_act}, 32'd0);
      @(negedge CPU_CLK);
      RST = 1'b1;
      #1;
      chk("rstfill_act_after", {31'b0, mem_act}, 32'd0);
      chk("rstfill_busy_after", {31'b0, cpu_busy}, 32'd0);
      @(negedge CPU_CLK);
      base = tlog.size();
      cpu_rd(32'h100, 1'b0, d, pre, post);
      chk("post_rst_miss", 32'(post > 0), 32'd1);
      chk("post_rst_fill0", tlog[base], 32'h0000_0100);
      chk("post_rst_data", d, 32'hDEAD_BEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
